// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM waveform in clk1ms ticks and flags a stuck line.
// Optional macro PWM_CAP_SYNC_EN adds a 2-flop synchronizer ahead of the sampling flops.
module pwm_capture #(
  parameter int WIDTH   = 26,
  parameter int TIMEOUT = 2000
) (
  input  logic             clk1ms,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    HIGH = 2'b10,
    LOW  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] TO_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           st;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_lat;
  logic             pwm_q, pwm_qq;
  logic             pwm_s;
  logic             primed;
  logic             rise, fall, stall;

`ifdef PWM_CAP_SYNC_EN
  logic [1:0] sync_ff;
  logic [2:0] prime_sh;

  always_ff @(posedge clk1ms) begin
    if (reset) begin
      sync_ff  <= '0;
      prime_sh <= '0;
    end else begin
      sync_ff  <= {sync_ff[0], pwm_in};
      prime_sh <= {prime_sh[1:0], 1'b1};
    end
  end

  assign pwm_s  = sync_ff[1];
  assign primed = prime_sh[2];
`else
  logic primed_r;

  always_ff @(posedge clk1ms) begin
    if (reset) primed_r <= 1'b0;
    else       primed_r <= 1'b1;
  end

  assign pwm_s  = pwm_in;
  assign primed = primed_r;
`endif

  assign rise  = primed &  pwm_q & ~pwm_qq;
  assign fall  = primed & ~pwm_q &  pwm_qq;
  // Any edge at the limit wins over the timeout.
  assign stall = (cnt == TO_CNT) && !rise && !fall;
  assign state = st;

  always_ff @(posedge clk1ms) begin
    if (reset) begin
      st          <= IDLE;
      cnt         <= '0;
      hi_lat      <= '0;
      pwm_q       <= 1'b0;
      pwm_qq      <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      pwm_q      <= pwm_s;
      pwm_qq     <= pwm_q;
      meas_valid <= 1'b0;
      if (st != IDLE && stall) begin
        timeout     <= 1'b1;
        stuck_level <= pwm_q;
        cnt         <= '0;
        st          <= IDLE;
      end else begin
        unique case (st)
          IDLE: begin
            cnt <= '0;
            // Wait for a low line so the first high phase is never truncated.
            if (primed && !pwm_q) st <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt <= ONE;
              st  <= HIGH;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          HIGH: begin
            cnt <= cnt + ONE;
            if (fall) begin
              hi_lat <= cnt;
              st     <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              period_out <= cnt;
              high_out   <= hi_lat;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              cnt        <= ONE;
              st         <= HIGH;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: driven waveforms are turned into expected
// (period, high) pairs and compared against the strobes the DUT publishes.
module tb_pwm_capture;
  localparam int W  = 26;
  localparam int TO = 20;

  logic         clk1ms = 1'b0;
  logic         reset  = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period_out, high_out;
  logic         meas_valid, timeout, stuck_level;
  logic [1:0]   state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int           mv_cyc[$];
  logic [W-1:0] mv_per[$];
  logic [W-1:0] mv_hi[$];
  int           exp_per[$];
  int           exp_hi[$];

  pwm_capture #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk1ms(clk1ms), .reset(reset), .pwm_in(pwm_in),
    .period_out(period_out), .high_out(high_out), .meas_valid(meas_valid),
    .timeout(timeout), .stuck_level(stuck_level), .state(state)
  );

  always #5 clk1ms = ~clk1ms;
  always @(posedge clk1ms) cyc <= cyc + 1;

  always @(negedge clk1ms) begin
    if (meas_valid === 1'b1) begin
      mv_cyc.push_back(cyc);
      mv_per.push_back(period_out);
      mv_hi.push_back(high_out);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wave(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) begin @(posedge clk1ms); #1; end
  endtask

  // One full period; it will be reported at the following rise.
  task automatic per(input int h, input int l);
    wave(1'b1, h);
    wave(1'b0, l);
    exp_per.push_back(h + l);
    exp_hi.push_back(h);
  endtask

  task automatic close_run;
    wave(1'b1, 1);
    wave(1'b0, 6);
  endtask

  task automatic start(input logic lvl);
    reset  = 1'b1;
    pwm_in = lvl;
    repeat (2) begin @(posedge clk1ms); #1; end
    reset = 1'b0;
    mv_cyc.delete(); mv_per.delete(); mv_hi.delete();
    exp_per.delete(); exp_hi.delete();
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(posedge clk1ms);
    @(negedge clk1ms);
    n_cmp++;
    if ({period_out, high_out, meas_valid, timeout, stuck_level, state} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got per=%0d hi=%0d mv=%b to=%b sl=%b st=%0d, expected all 0",
               period_out, high_out, meas_valid, timeout, stuck_level, state);
    end
  endtask

  task automatic test_basic;
    start(1'b0);
    wave(1'b0, 3);
    repeat (5) per(3, 5);
    close_run();
    n_cmp++;
    if (mv_per.size() != exp_per.size()) begin
      n_bad++;
      $display("FAIL basic_count: got %0d strobes, expected %0d", mv_per.size(), exp_per.size());
    end
    for (int i = 0; i < exp_per.size() && i < mv_per.size(); i++) begin
      n_cmp++;
      if (mv_per[i] !== W'(exp_per[i]) || mv_hi[i] !== W'(exp_hi[i])) begin
        n_bad++;
        $display("FAIL basic_meas[%0d]: got per=%0d hi=%0d, expected per=%0d hi=%0d",
                 i, mv_per[i], mv_hi[i], exp_per[i], exp_hi[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (mv_cyc[i] - mv_cyc[i-1] != exp_per[i]) begin
          n_bad++;
          $display("FAIL basic_spacing[%0d]: got %0d cycles, expected %0d",
                   i, mv_cyc[i] - mv_cyc[i-1], exp_per[i]);
        end
      end
    end
    n_cmp++;
    if (state !== 2'b11 || meas_valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle_low: got st=%0d mv=%b to=%b, expected st=3 mv=0 to=0",
               state, meas_valid, timeout);
    end
  endtask

  task automatic test_high_at_reset;
    start(1'b1);
    wave(1'b1, 4);
    wave(1'b0, 2);
    repeat (4) per(2, 2);
    close_run();
    n_cmp++;
    if (mv_per.size() != exp_per.size()) begin
      n_bad++;
      $display("FAIL hi_reset_count: got %0d strobes, expected %0d", mv_per.size(), exp_per.size());
    end
    for (int i = 0; i < exp_per.size() && i < mv_per.size(); i++) begin
      n_cmp++;
      if (mv_per[i] !== W'(exp_per[i]) || mv_hi[i] !== W'(exp_hi[i])) begin
        n_bad++;
        $display("FAIL hi_reset_meas[%0d]: got per=%0d hi=%0d, expected per=%0d hi=%0d",
                 i, mv_per[i], mv_hi[i], exp_per[i], exp_hi[i]);
      end
    end
  endtask

  task automatic test_random;
    start(1'b0);
    wave(1'b0, 3);
    repeat (12) per(int'($urandom_range(1, 8)), int'($urandom_range(1, 10)));
    close_run();
    n_cmp++;
    if (mv_per.size() != exp_per.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d strobes, expected %0d", mv_per.size(), exp_per.size());
    end
    for (int i = 0; i < exp_per.size() && i < mv_per.size(); i++) begin
      n_cmp++;
      if (mv_per[i] !== W'(exp_per[i]) || mv_hi[i] !== W'(exp_hi[i])) begin
        n_bad++;
        $display("FAIL rand_meas[%0d]: got per=%0d hi=%0d, expected per=%0d hi=%0d",
                 i, mv_per[i], mv_hi[i], exp_per[i], exp_hi[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (mv_cyc[i] - mv_cyc[i-1] != exp_per[i]) begin
          n_bad++;
          $display("FAIL rand_spacing[%0d]: got %0d cycles, expected %0d",
                   i, mv_cyc[i] - mv_cyc[i-1], exp_per[i]);
        end
      end
    end
  endtask

  task automatic test_stuck_high;
    bit got = 0;
    int t_to = 0;
    start(1'b0);
    wave(1'b0, 3);
    per(3, 5);
    per(3, 5);
    pwm_in = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk1ms);
      if (timeout === 1'b1) begin got = 1; t_to = cyc; end
    end
    @(posedge clk1ms); #1;
    n_cmp++;
    if (!got || mv_cyc.size() == 0) begin
      n_bad++;
      $display("FAIL stuck_hi_fire: got timeout=%b strobes=%0d, expected timeout after a strobe",
               got, mv_cyc.size());
    end else if (t_to - mv_cyc[mv_cyc.size()-1] != TO) begin
      n_bad++;
      $display("FAIL stuck_hi_delay: got %0d cycles after last rise, expected %0d",
               t_to - mv_cyc[mv_cyc.size()-1], TO);
    end
    wave(1'b1, 2);
    n_cmp++;
    if (timeout !== 1'b1 || stuck_level !== 1'b1 || state !== 2'b00) begin
      n_bad++;
      $display("FAIL stuck_hi_state: got to=%b sl=%b st=%0d, expected to=1 sl=1 st=0",
               timeout, stuck_level, state);
    end
    mv_cyc.delete(); mv_per.delete(); mv_hi.delete();
    exp_per.delete(); exp_hi.delete();
    wave(1'b0, 5);
    wave(1'b1, 3);
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL stuck_hi_rearm_hold: got to=%b, expected 1", timeout);
    end
    wave(1'b0, 5);
    exp_per.push_back(8);
    exp_hi.push_back(3);
    per(3, 5);
    close_run();
    n_cmp++;
    if (mv_per.size() != 2 || mv_per[0] !== W'(8) || mv_hi[0] !== W'(3) || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL stuck_hi_resume: got n=%0d per=%0d hi=%0d to=%b, expected n=2 per=8 hi=3 to=0",
               mv_per.size(), (mv_per.size() > 0) ? mv_per[0] : '0,
               (mv_hi.size() > 0) ? mv_hi[0] : '0, timeout);
    end
  endtask

  task automatic test_stuck_low;
    int  idle_cyc[$];
    bit  seen_to  = 0;
    bit  seen_arm = 0;
    start(1'b0);
    pwm_in = 1'b0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk1ms);
      if (timeout === 1'b1) seen_to = 1;
      if (seen_to && state === 2'b00) idle_cyc.push_back(cyc);
      if (seen_to && state === 2'b01) seen_arm = 1;
    end
    @(posedge clk1ms); #1;
    n_cmp++;
    if (!seen_to || stuck_level !== 1'b0 || !seen_arm) begin
      n_bad++;
      $display("FAIL stuck_lo_flag: got to=%b sl=%b arm=%b, expected to=1 sl=0 arm=1",
               seen_to, stuck_level, seen_arm);
    end
    n_cmp++;
    if (idle_cyc.size() < 2) begin
      n_bad++;
      $display("FAIL stuck_lo_rearm: got %0d idle visits, expected at least 2", idle_cyc.size());
    end else if (idle_cyc[1] - idle_cyc[0] != TO + 2) begin
      n_bad++;
      $display("FAIL stuck_lo_rearm: got %0d cycles between idle visits, expected %0d",
               idle_cyc[1] - idle_cyc[0], TO + 2);
    end
    n_cmp++;
    if (mv_per.size() != 0) begin
      n_bad++;
      $display("FAIL stuck_lo_nostrobe: got %0d strobes, expected 0", mv_per.size());
    end
  endtask

  task automatic test_edge_at_timeout;
    start(1'b0);
    wave(1'b0, 3);
    repeat (3) per(1, TO - 1);
    close_run();
    n_cmp++;
    if (timeout !== 1'b0 || mv_per.size() != exp_per.size()) begin
      n_bad++;
      $display("FAIL edge_to_count: got to=%b n=%0d, expected to=0 n=%0d",
               timeout, mv_per.size(), exp_per.size());
    end
    for (int i = 0; i < exp_per.size() && i < mv_per.size(); i++) begin
      n_cmp++;
      if (mv_per[i] !== W'(exp_per[i]) || mv_hi[i] !== W'(exp_hi[i])) begin
        n_bad++;
        $display("FAIL edge_to_meas[%0d]: got per=%0d hi=%0d, expected per=%0d hi=%0d",
                 i, mv_per[i], mv_hi[i], exp_per[i], exp_hi[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    start(1'b0);
    wave(1'b0, 3);
    per(3, 5);
    wave(1'b1, 5);
    n_cmp++;
    if (period_out !== W'(8) || state !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_pre: got per=%0d st=%0d, expected per=8 st=2", period_out, state);
    end
    reset = 1'b1;
    @(posedge clk1ms); #1;
    n_cmp++;
    if ({period_out, high_out, meas_valid, timeout, stuck_level, state} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got per=%0d hi=%0d mv=%b to=%b sl=%b st=%0d, expected all 0",
               period_out, high_out, meas_valid, timeout, stuck_level, state);
    end
    reset = 1'b0;
    mv_cyc.delete(); mv_per.delete(); mv_hi.delete();
    exp_per.delete(); exp_hi.delete();
    wave(1'b1, 1);
    wave(1'b0, 5);
    per(3, 5);
    close_run();
    n_cmp++;
    if (mv_per.size() != 1 || mv_per[0] !== W'(8) || mv_hi[0] !== W'(3)) begin
      n_bad++;
      $display("FAIL mid_after: got n=%0d per=%0d hi=%0d, expected n=1 per=8 hi=3",
               mv_per.size(), (mv_per.size() > 0) ? mv_per[0] : '0,
               (mv_hi.size() > 0) ? mv_hi[0] : '0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_high_at_reset();
    test_random();
    test_stuck_high();
    test_stuck_low();
    test_edge_at_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
